// File: rtl/stdin_word_fifo.sv
// Byte-to-word input buffer: pairs host bytes (high first) into 16-bit words and queues them
// in a first-word-fall-through FIFO. Optional flush port enabled by defining STDIN_FLUSH_EN.
module stdin_word_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     byte_val_i,
    input  logic [7:0]               byte_data_i,
    output logic                     byte_rdy_o,
    output logic                     word_val_o,
    output logic [15:0]              word_data_o,
    input  logic                     word_rdy_i,
    output logic [$clog2(DEPTH):0]   level_o,
`ifdef STDIN_FLUSH_EN
    input  logic                     flush_i,
`endif
    output logic                     partial_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {HI = 1'b0, LO = 1'b1} state_t;

    state_t          state_reg;
    logic [7:0]      hi_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     level_reg;
    logic [15:0]     mem [DEPTH];

    logic            flush;
    logic            full;
    logic            accept;
    logic            push;
    logic            pop;

`ifdef STDIN_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Ready is decoded from registered state only, so a pop never frees space for the same edge.
    assign full       = (level_reg == DEPTH[AW:0]);
    assign byte_rdy_o = (state_reg == HI) || !full;
    assign accept     = byte_val_i && byte_rdy_o;
    assign push       = accept && (state_reg == LO);
    assign word_val_o = (level_reg != '0);
    assign pop        = word_val_o && word_rdy_i;

    assign word_data_o = word_val_o ? mem[rd_ptr_reg] : 16'h0000;
    assign level_o     = level_reg;
    assign partial_o   = (state_reg == LO);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= HI;
            hi_reg     <= 8'h00;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            state_reg  <= HI;
            hi_reg     <= 8'h00;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (accept) begin
                if (state_reg == HI) begin
                    hi_reg    <= byte_data_i;
                    state_reg <= LO;
                end else begin
                    state_reg <= HI;
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop && !push) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= {hi_reg, byte_data_i};
        end
    end

endmodule

// File: tb/tb_stdin_word_fifo.sv
// Directed bench for stdin_word_fifo at DEPTH=4: per-cycle vector table plus wrap and flush sequences.
module tb_stdin_word_fifo;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            byte_val = 1'b0;
    logic [7:0]      byte_data = 8'h00;
    logic            byte_rdy;
    logic            word_val;
    logic [15:0]     word_data;
    logic            word_rdy = 1'b0;
    logic [LW-1:0]   level;
    logic            partial;
`ifdef STDIN_FLUSH_EN
    logic            flush = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stdin_word_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .byte_val_i  (byte_val),
        .byte_data_i (byte_data),
        .byte_rdy_o  (byte_rdy),
        .word_val_o  (word_val),
        .word_data_o (word_data),
        .word_rdy_i  (word_rdy),
        .level_o     (level),
`ifdef STDIN_FLUSH_EN
        .flush_i     (flush),
`endif
        .partial_o   (partial)
    );

    typedef struct {
        logic        rst;
        logic        bv;
        logic [7:0]  bd;
        logic        wr;
        logic        chk;
        logic        e_brdy;
        logic        e_wval;
        logic [15:0] e_data;
        int          e_level;
        logic        e_part;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic bv, input logic [7:0] bd, input logic wr,
                       input logic chk, input logic brdy, input logic wval, input logic [15:0] d,
                       input int lvl, input logic part);
        vec_t v;
        v.rst = r; v.bv = bv; v.bd = bd; v.wr = wr; v.chk = chk;
        v.e_brdy = brdy; v.e_wval = wval; v.e_data = d; v.e_level = lvl; v.e_part = part;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input logic brdy, input logic wval,
                               input logic [15:0] d, input int lvl, input logic part);
        check({tag, ".byte_rdy"},  int'(byte_rdy),  int'(brdy));
        check({tag, ".word_val"},  int'(word_val),  int'(wval));
        check({tag, ".word_data"}, int'(word_data), int'(d));
        check({tag, ".level"},     int'(level),     lvl);
        check({tag, ".partial"},   int'(partial),   int'(part));
    endtask

    // Drive one byte over one cycle (inputs set on the falling edge).
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_val  = 1'b1;
        byte_data = b;
        @(negedge clk);
        byte_val  = 1'b0;
    endtask

    initial begin
        // Expected outputs describe the state seen at this row's falling edge, before its inputs apply.
        //   rst bv  bd     wr chk brdy wval data      lvl part
        add(1, 0, 8'h00, 0, 0, 1, 0, 16'h0000, 0, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0);   // reset values
        add(0, 1, 8'h12, 0, 1, 1, 0, 16'h0000, 0, 0);
        add(0, 1, 8'h34, 0, 1, 1, 0, 16'h0000, 0, 1);   // partial between bytes
        add(0, 0, 8'h00, 0, 1, 1, 1, 16'h1234, 1, 0);   // 1-cycle byte-to-word latency
        add(0, 0, 8'h00, 1, 1, 1, 1, 16'h1234, 1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0);   // popped, empty reads zero
        // fill to DEPTH with words 0001..0004
        add(0, 1, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0);
        add(0, 1, 8'h01, 0, 1, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 8'h00, 0, 1, 1, 1, 16'h0001, 1, 0);
        add(0, 1, 8'h02, 0, 1, 1, 1, 16'h0001, 1, 1);
        add(0, 1, 8'h00, 0, 1, 1, 1, 16'h0001, 2, 0);
        add(0, 1, 8'h03, 0, 1, 1, 1, 16'h0001, 2, 1);
        add(0, 1, 8'h00, 0, 1, 1, 1, 16'h0001, 3, 0);
        add(0, 1, 8'h04, 0, 1, 1, 1, 16'h0001, 3, 1);
        add(0, 1, 8'h00, 0, 1, 1, 1, 16'h0001, 4, 0);   // 9th byte (high) still accepted
        add(0, 1, 8'h05, 0, 1, 0, 1, 16'h0001, 4, 1);   // 10th byte stalls
        add(0, 1, 8'h05, 0, 1, 0, 1, 16'h0001, 4, 1);
        add(0, 1, 8'h05, 1, 1, 0, 1, 16'h0001, 4, 1);   // pop cycle: still refused
        add(0, 1, 8'h05, 0, 1, 1, 1, 16'h0002, 3, 1);   // accepted the cycle after the pop
        add(0, 0, 8'h00, 0, 1, 1, 1, 16'h0002, 4, 0);
        // drain to two, then push and pop on the same edge
        add(0, 0, 8'h00, 1, 1, 1, 1, 16'h0002, 4, 0);
        add(0, 0, 8'h00, 1, 1, 1, 1, 16'h0003, 3, 0);
        add(0, 1, 8'h0A, 0, 1, 1, 1, 16'h0004, 2, 0);
        add(0, 1, 8'h0B, 1, 1, 1, 1, 16'h0004, 2, 1);
        add(0, 0, 8'h00, 0, 1, 1, 1, 16'h0005, 2, 0);   // level held at 2
        add(0, 0, 8'h00, 1, 1, 1, 1, 16'h0005, 2, 0);
        add(0, 0, 8'h00, 1, 1, 1, 1, 16'h0A0B, 1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0);
        // reset mid-word drops 0xAB
        add(0, 1, 8'hAB, 0, 1, 1, 0, 16'h0000, 0, 0);
        add(1, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 1);
        add(0, 1, 8'hCD, 0, 1, 1, 0, 16'h0000, 0, 0);
        add(0, 1, 8'hEF, 0, 1, 1, 0, 16'h0000, 0, 1);
        add(0, 0, 8'h00, 0, 1, 1, 1, 16'hCDEF, 1, 0);
        add(0, 0, 8'h00, 1, 1, 1, 1, 16'hCDEF, 1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0);
        // reset while non-empty discards queued words
        add(0, 1, 8'h11, 0, 1, 1, 0, 16'h0000, 0, 0);
        add(0, 1, 8'h22, 0, 1, 1, 0, 16'h0000, 0, 1);
        add(1, 0, 8'h00, 0, 1, 1, 1, 16'h1122, 1, 0);
        add(0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            if (vecs[i].chk) begin
                check_state($sformatf("vec%0d", i), vecs[i].e_brdy, vecs[i].e_wval,
                            vecs[i].e_data, vecs[i].e_level, vecs[i].e_part);
            end
            rst       = vecs[i].rst;
            byte_val  = vecs[i].bv;
            byte_data = vecs[i].bd;
            word_rdy  = vecs[i].wr;
            $display("vec%0d rst=%0b bv=%0b bd=%02h wr=%0b | brdy=%0b wval=%0b data=%04h lvl=%0d part=%0b",
                     i, rst, byte_val, byte_data, word_rdy, byte_rdy, word_val, word_data, level, partial);
        end
        @(negedge clk);
        rst = 1'b0; byte_val = 1'b0; word_rdy = 1'b0;

        // Wrap: 20 words through with the consumer always ready.
        begin
            logic [15:0] expq[$];
            int sent = 0;
            int got  = 0;
            int phase = 0;
            word_rdy = 1'b1;
            for (int cyc = 0; cyc < 80; cyc++) begin
                @(negedge clk);
                if (word_val) begin
                    if (expq.size() == 0) begin
                        check("wrap.unexpected_word", int'(word_data), -1);
                    end else begin
                        check($sformatf("wrap.word%0d", got), int'(word_data), int'(expq.pop_front()));
                        $display("wrap word%0d data=%04h lvl=%0d", got, word_data, level);
                    end
                    got++;
                end
                byte_val = 1'b0;
                if (sent < 20) begin
                    byte_val  = 1'b1;
                    byte_data = (phase == 0) ? 8'(sent + 8'h40) : 8'(8'hC0 - sent);
                    if (phase == 1) begin
                        expq.push_back({8'(sent + 8'h40), 8'(8'hC0 - sent)});
                        sent++;
                    end
                    phase ^= 1;
                end
            end
            check("wrap.count", got, 20);
            check("wrap.level", int'(level), 0);
            word_rdy = 1'b0;
        end

`ifdef STDIN_FLUSH_EN
        // Flush with three words plus a partial byte queued and a pop requested.
        send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06);
        send_byte(8'h07);
        @(negedge clk);
        check_state("flush.pre", 1'b1, 1'b1, 16'h0102, 3, 1'b1);
        flush = 1'b1; word_rdy = 1'b1; byte_val = 1'b1; byte_data = 8'h99;
        @(negedge clk);
        flush = 1'b0; word_rdy = 1'b0; byte_val = 1'b0;
        check_state("flush.post", 1'b1, 1'b0, 16'h0000, 0, 1'b0);
        $display("flush lvl=%0d part=%0b wval=%0b", level, partial, word_val);
        send_byte(8'h55);
        check("flush.partial", int'(partial), 1);
        @(negedge clk);
        byte_val = 1'b1; byte_data = 8'h66;
        @(negedge clk);
        byte_val = 1'b0;
        check_state("flush.next", 1'b1, 1'b1, 16'h5566, 1, 1'b0);
        $display("flush next word data=%04h", word_data);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
